// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DIV_9600  = 326;
    localparam int DIV_2400  = 1302;
    localparam int SAMPLE_PT = 7;

    localparam int WORD7 = 7;
    localparam int WORD8 = 8;
    localparam int STOP1 = 1;
    localparam int STOP2 = 2;

endpackage

// File: rtl/uart_os_tick.sv
// 16x oversampling tick divider; held at zero while restart is high.
module uart_os_tick #(
    parameter int DIV_9600 = 326,
    parameter int DIV_2400 = 1302
) (
    input  logic clk,
    input  logic rst,
    input  logic rate_sel,
    input  logic restart,
    output logic tick
);
    logic [15:0] cnt;
    logic [15:0] div_m1;

    assign div_m1 = rate_sel ? 16'(DIV_9600 - 1) : 16'(DIV_2400 - 1);
    assign tick   = !restart && (cnt == div_m1);

    always_ff @(posedge clk) begin
        if (rst || restart || cnt == div_m1)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled mid-bit sampling, framing and
// alternating all-0/all-1 pattern checking.
module uart_rx #(
    parameter int DIV_9600 = uart_pkg::DIV_9600,
    parameter int DIV_2400 = uart_pkg::DIV_2400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       word8,
    input  logic       stop2,
    input  logic       rate_sel,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       pattern_err,
    output logic       busy
);
    import uart_pkg::*;

    state_t     state;
    logic       s1, s2, s3;
    logic [3:0] tidx;
    logic [3:0] bcnt;
    logic [7:0] sh, prev;
    logic       w8_l, st2_l, rate_l, ferr;
    logic       tick;

    logic [7:0] char_c;
    logic [7:0] full;
    logic       same, pat_bad;
    logic [3:0] last_bit, last_stop;

    uart_os_tick #(.DIV_9600(DIV_9600), .DIV_2400(DIV_2400)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .rate_sel (rate_l),
        .restart  (state == IDLE),
        .tick     (tick)
    );

    // In 7-bit mode the LSB-first shift leaves the char in sh[7:1].
    always_comb begin
        char_c    = w8_l ? sh : {1'b0, sh[7:1]};
        full      = w8_l ? 8'hFF : 8'h7F;
        same      = w8_l ? (char_c == prev) : (char_c[6:0] == prev[6:0]);
        pat_bad   = !(char_c == 8'h00 || char_c == full) || same;
        last_bit  = w8_l  ? 4'(WORD8 - 1) : 4'(WORD7 - 1);
        last_stop = st2_l ? 4'(STOP2 - 1) : 4'(STOP1 - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s1          <= 1'b1;
            s2          <= 1'b1;
            s3          <= 1'b1;
            tidx        <= '0;
            bcnt        <= '0;
            sh          <= '0;
            prev        <= '0;
            w8_l        <= 1'b0;
            st2_l       <= 1'b0;
            rate_l      <= 1'b0;
            ferr        <= 1'b0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            pattern_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            s1         <= rxd;
            s2         <= s1;
            s3         <= s2;
            data_valid <= 1'b0;
            case (state)
                IDLE: if (s3 && !s2) begin
                    state  <= START;
                    busy   <= 1'b1;
                    tidx   <= '0;
                    w8_l   <= word8;
                    st2_l  <= stop2;
                    rate_l <= rate_sel;
                end
                START: if (tick) begin
                    if (tidx == 4'(SAMPLE_PT)) begin
                        if (!s2) begin
                            state <= DATA;
                            tidx  <= '0;
                            bcnt  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tidx <= tidx + 4'd1;
                    end
                end
                // Index 15 after the start-bit reset lands 16 ticks on: mid-bit.
                DATA: if (tick) begin
                    tidx <= tidx + 4'd1;
                    if (tidx == 4'd15) begin
                        sh   <= {s2, sh[7:1]};
                        bcnt <= bcnt + 4'd1;
                        if (bcnt == last_bit) begin
                            state <= STOP;
                            bcnt  <= '0;
                            ferr  <= 1'b0;
                        end
                    end
                end
                STOP: if (tick) begin
                    tidx <= tidx + 4'd1;
                    if (tidx == 4'd15) begin
                        if (bcnt == last_stop) begin
                            data        <= char_c;
                            frame_err   <= ferr | !s2;
                            pattern_err <= pat_bad;
                            prev        <= char_c;
                            data_valid  <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            ferr <= ferr | !s2;
                            bcnt <= bcnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with shortened baud dividers.
module tb_uart_rx;
    localparam int DF   = 8;
    localparam int DS   = 20;
    localparam int BT_F = 16 * DF;
    localparam int BT_S = 16 * DS;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       word8 = 1'b1, stop2 = 1'b0, rate_sel = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, pattern_err, busy;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    uart_rx #(.DIV_9600(DF), .DIV_2400(DS)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .word8       (word8),
        .stop2       (stop2),
        .rate_sel    (rate_sel),
        .data        (data),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .pattern_err (pattern_err),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; checks busy mid data bit 0 and late in the final stop bit.
    task automatic send(input logic [7:0] c, input int nbits, input int nstop,
                        input int bt, input logic stopv);
        rxd = 1'b0;
        wait_clk(bt);
        for (int i = 0; i < nbits; i++) begin
            rxd = c[i];
            if (i == 0) begin
                wait_clk(bt / 2);
                chk("busy_in_frame", 8'(busy), 8'd1);
                wait_clk(bt - bt / 2);
            end else begin
                wait_clk(bt);
            end
        end
        for (int s = 0; s < nstop; s++) begin
            rxd = stopv;
            if (s == nstop - 1) begin
                wait_clk(3 * bt / 4);
                chk("busy_after_stop", 8'(busy), 8'd0);
                wait_clk(bt - 3 * bt / 4);
            end else begin
                wait_clk(bt);
            end
        end
    endtask

    task automatic expect_char(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.pe = pe;
        q.push_back(e);
    endtask

    // Monitor: every data_valid must match the oldest expected character.
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got data=%h fe=%b pe=%b expected no pulse",
                         data, frame_err, pattern_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data !== e.d || frame_err !== e.fe || pattern_err !== e.pe) begin
                    failures++;
                    $display("FAIL rx_char: got data=%h fe=%b pe=%b expected data=%h fe=%b pe=%b",
                             data, frame_err, pattern_err, e.d, e.fe, e.pe);
                end
            end
        end
    end

    initial begin
        wait_clk(3);
        rst = 1'b0;
        chk("rst_data", data, 8'h00);
        chk("rst_busy", 8'(busy), 8'd0);

        // Idle line: nothing happens.
        wait_clk(2000);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_valid", 8'(data_valid), 8'd0);
        chk("idle_fe", 8'(frame_err), 8'd0);
        chk("idle_pe", 8'(pattern_err), 8'd0);
        chk("idle_data", data, 8'h00);

        // 9600, 8N1, back-to-back.
        rate_sel = 1'b1; word8 = 1'b1; stop2 = 1'b0;
        expect_char(8'hFF, 1'b0, 1'b0);
        expect_char(8'h00, 1'b0, 1'b0);
        send(8'hFF, 8, 1, BT_F, 1'b1);
        send(8'h00, 8, 1, BT_F, 1'b1);
        wait_clk(BT_F);

        // 2400, 7 data bits, 2 stop bits.
        rate_sel = 1'b0; word8 = 1'b0; stop2 = 1'b1;
        expect_char(8'h7F, 1'b0, 1'b0);
        expect_char(8'h00, 1'b0, 1'b0);
        expect_char(8'h00, 1'b0, 1'b1);
        send(8'h7F, 7, 2, BT_S, 1'b1);
        send(8'h00, 7, 2, BT_S, 1'b1);
        send(8'h00, 7, 2, BT_S, 1'b1);
        wait_clk(BT_S);

        // Bad stop bit, then a good frame clears frame_err.
        rate_sel = 1'b1; word8 = 1'b1; stop2 = 1'b0;
        expect_char(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 8, 1, BT_F, 1'b0);
        rxd = 1'b1;
        wait_clk(BT_F);
        chk("fe_held", 8'(frame_err), 8'd1);
        expect_char(8'h00, 1'b0, 1'b0);
        send(8'h00, 8, 1, BT_F, 1'b1);
        wait_clk(BT_F);

        // Start-bit glitch aborts without a character.
        rxd = 1'b0;
        wait_clk(10);
        chk("glitch_busy_hi", 8'(busy), 8'd1);
        wait_clk(10);
        rxd = 1'b1;
        wait_clk(100);
        chk("glitch_busy_lo", 8'(busy), 8'd0);
        wait_clk(BT_F);

        // Reset in the middle of a frame.
        expect_char(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 8, 1, BT_F, 1'b1);
        wait_clk(BT_F);
        rxd = 1'b0;
        wait_clk(BT_F);
        rxd = 1'b1;
        wait_clk(3 * BT_F);
        chk("mid_busy", 8'(busy), 8'd1);
        rst = 1'b1;
        wait_clk(1);
        chk("mrst_data", data, 8'h00);
        chk("mrst_busy", 8'(busy), 8'd0);
        chk("mrst_fe", 8'(frame_err), 8'd0);
        chk("mrst_pe", 8'(pattern_err), 8'd0);
        chk("mrst_valid", 8'(data_valid), 8'd0);
        rst = 1'b0;
        wait_clk(2 * BT_F);
        expect_char(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 8, 1, BT_F, 1'b1);
        wait_clk(2 * BT_F);

        chk("queue_empty", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
